// File: rtl/phy_reset_sequencer.sv
// Purpose: holds N_CH PHYs in reset until the PLL is stably locked, then releases and qualifies each channel.
// Latency: phy_reset_b rises LOCK_FILT+HOLD_CYCLES edges after lock starts; ready follows SETTLE_CYCLES edges later.
// Backpressure: none; all inputs are sampled every cycle and all outputs are plain registers.
module phy_reset_sequencer #(
    parameter int N_CH          = 2,
    parameter int CW            = 24,
    parameter int HOLD_CYCLES   = 1250000,
    parameter int SETTLE_CYCLES = 625000,
    parameter int LOCK_FILT     = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_locked,
    input  logic [N_CH-1:0] soft_rst,
    input  logic            clr_status,
    output logic [N_CH-1:0] phy_reset_b,
    output logic [N_CH-1:0] ready,
    output logic            locked_ok,
    output logic            lock_lost,
    output logic [7:0]      restart_cnt
);

    // Lock filter counter only needs to reach LOCK_FILT, where it saturates.
    localparam int LW = (LOCK_FILT < 1) ? 1 : $clog2(LOCK_FILT + 1);
    localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_FILT);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } ch_state_t;

    // ------------------------------------------------------------------
    // Lock filter: lock is declared only after LOCK_FILT consecutive
    // locked samples; a single unlocked sample drops it immediately.
    // ------------------------------------------------------------------
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_nxt;
    logic          locked_ok_nxt;

    // Next filter count and filtered lock flag.
    always_comb begin
        lock_cnt_nxt  = '0;
        locked_ok_nxt = 1'b0;
        if (pll_locked) begin
            if (lock_cnt == LOCK_MAX) begin
                lock_cnt_nxt = lock_cnt;
            end else begin
                lock_cnt_nxt = lock_cnt + 1'b1;
            end
            locked_ok_nxt = (lock_cnt_nxt == LOCK_MAX);
        end
    end

    // Filter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt  <= '0;
            locked_ok <= 1'b0;
        end else begin
            lock_cnt  <= lock_cnt_nxt;
            locked_ok <= locked_ok_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Diagnostics: a loss event is the edge where the filtered lock
    // drops. A clear arriving with a loss still records that loss.
    // ------------------------------------------------------------------
    logic       loss_evt;
    logic       lock_lost_nxt;
    logic [7:0] restart_cnt_nxt;

    // Sticky loss flag and saturating restart counter update.
    always_comb begin
        loss_evt        = locked_ok && !locked_ok_nxt;
        lock_lost_nxt   = lock_lost;
        restart_cnt_nxt = restart_cnt;
        if (clr_status && loss_evt) begin
            lock_lost_nxt   = 1'b1;
            restart_cnt_nxt = 8'd1;
        end else if (clr_status) begin
            lock_lost_nxt   = 1'b0;
            restart_cnt_nxt = 8'd0;
        end else if (loss_evt) begin
            lock_lost_nxt = 1'b1;
            if (restart_cnt != 8'hFF) begin
                restart_cnt_nxt = restart_cnt + 8'd1;
            end
        end
    end

    // Diagnostic registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_lost   <= 1'b0;
            restart_cnt <= 8'd0;
        end else begin
            lock_lost   <= lock_lost_nxt;
            restart_cnt <= restart_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel sequencer. Loss of filtered lock forces every channel
    // back to HOLD on the same edge; soft_rst only affects its own lane.
    // Output pins are registered from the next state so they change on
    // the same edge as the state itself.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        ch_state_t state;
        ch_state_t state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          rst_b_q;
        logic          rdy_q;

        // Next-state and counter logic, highest-priority cause first.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (!locked_ok) begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end else if (soft_rst[ch]) begin
                // Holding soft_rst in HOLD pins the counter at zero, so
                // the hold time is measured from its deassertion.
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state_nxt = ST_SETTLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            state_nxt = ST_RUN;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        cnt_nxt = '0;
                    end
                    default: begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // Channel state, counter and output pin registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state   <= ST_HOLD;
                cnt     <= '0;
                rst_b_q <= 1'b0;
                rdy_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                rst_b_q <= (state_nxt != ST_HOLD);
                rdy_q   <= (state_nxt == ST_RUN);
            end
        end

        assign phy_reset_b[ch] = rst_b_q;
        assign ready[ch]       = rdy_q;
    end

endmodule

// File: tb/tb_phy_reset_sequencer.sv
// Purpose: self-checking bench for phy_reset_sequencer with directed scenarios and random stimulus.
// Latency: expected outputs come from an edge-count model updated at each rising edge.
// Backpressure: not applicable.
module tb_phy_reset_sequencer;

    localparam int N_CH   = 2;
    localparam int HOLD   = 8;
    localparam int SETTLE = 4;
    localparam int LF     = 3;
    localparam int CAP    = 1000000;

    logic            clk;
    logic            rst_n;
    logic            pll_locked;
    logic [N_CH-1:0] soft_rst;
    logic            clr_status;
    logic [N_CH-1:0] phy_reset_b;
    logic [N_CH-1:0] ready;
    logic            locked_ok;
    logic            lock_lost;
    logic [7:0]      restart_cnt;

    int errors = 0;
    int checks = 0;

    phy_reset_sequencer #(
        .N_CH          (N_CH),
        .CW            (24),
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_FILT     (LF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .soft_rst    (soft_rst),
        .clr_status  (clr_status),
        .phy_reset_b (phy_reset_b),
        .ready       (ready),
        .locked_ok   (locked_ok),
        .lock_lost   (lock_lost),
        .restart_cnt (restart_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a channel's progress is simply the number of
    // consecutive edges on which it saw filtered lock and no soft reset.
    // It is released after HOLD such edges and ready after HOLD+SETTLE.
    bit started = 0;
    int streak;
    bit m_lok;
    bit old_lok;
    bit loss;
    int run_n [N_CH];
    bit m_lost;
    int m_cnt;

    // Model update on each rising edge from the inputs sampled there.
    always @(posedge clk) begin
        started = 1;
        if (!rst_n) begin
            streak = 0;
            m_lok  = 0;
            m_lost = 0;
            m_cnt  = 0;
            for (int c = 0; c < N_CH; c++) run_n[c] = 0;
        end else begin
            old_lok = m_lok;
            for (int c = 0; c < N_CH; c++) begin
                if (old_lok && !soft_rst[c]) run_n[c] = (run_n[c] < CAP) ? run_n[c] + 1 : CAP;
                else                         run_n[c] = 0;
            end
            streak = pll_locked ? ((streak < CAP) ? streak + 1 : CAP) : 0;
            m_lok  = (streak >= LF);
            loss   = old_lok && !m_lok;
            if (clr_status && loss) begin
                m_lost = 1;
                m_cnt  = 1;
            end else if (clr_status) begin
                m_lost = 0;
                m_cnt  = 0;
            end else if (loss) begin
                m_lost = 1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            logic [N_CH-1:0] e_phy;
            logic [N_CH-1:0] e_rdy;
            for (int c = 0; c < N_CH; c++) begin
                e_phy[c] = (run_n[c] >= HOLD);
                e_rdy[c] = (run_n[c] >= HOLD + SETTLE);
            end
            chk("model_phy_reset_b", 32'(phy_reset_b), 32'(e_phy));
            chk("model_ready",       32'(ready),       32'(e_rdy));
            chk("model_locked_ok",   32'(locked_ok),   32'(m_lok));
            chk("model_lock_lost",   32'(lock_lost),   32'(m_lost));
            chk("model_restart_cnt", 32'(restart_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_phy"},   32'(phy_reset_b), 32'd0);
        chk({name, "_ready"}, 32'(ready),       32'd0);
        chk({name, "_lok"},   32'(locked_ok),   32'd0);
        chk({name, "_lost"},  32'(lock_lost),   32'd0);
        chk({name, "_cnt"},   32'(restart_cnt), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        soft_rst   = '0;
        clr_status = 1'b0;

        // Power-up: reset for 5 cycles with PLL already locked.
        repeat (5) tick();
        check_all_zero("pwrup_reset");
        rst_n = 1'b1;
        repeat (10) tick();
        chk("pwrup_phy_edge10", 32'(phy_reset_b), 32'd0);
        tick();
        chk("pwrup_phy_edge11", 32'(phy_reset_b), 32'd3);
        repeat (3) tick();
        chk("pwrup_ready_edge14", 32'(ready), 32'd0);
        tick();
        chk("pwrup_ready_edge15", 32'(ready), 32'd3);

        // Lock glitch on the second filter sample restarts the filter.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        chk("glitch_phy_edge10", 32'(phy_reset_b), 32'd0);
        tick();
        chk("glitch_phy_edge11", 32'(phy_reset_b), 32'd3);
        repeat (4) tick();
        chk("glitch_ready", 32'(ready), 32'd3);

        // Loss of lock while running.
        pll_locked = 1'b0;
        tick();
        chk("loss_lost",  32'(lock_lost),   32'd1);
        chk("loss_cnt",   32'(restart_cnt), 32'd1);
        chk("loss_lok",   32'(locked_ok),   32'd0);
        pll_locked = 1'b1;
        tick();
        chk("loss_phy_low",   32'(phy_reset_b), 32'd0);
        chk("loss_ready_low", 32'(ready),       32'd0);
        repeat (9) tick();
        chk("relock_phy_edge10", 32'(phy_reset_b), 32'd0);
        tick();
        chk("relock_phy_edge11", 32'(phy_reset_b), 32'd3);
        repeat (3) tick();
        chk("relock_ready_edge14", 32'(ready), 32'd0);
        tick();
        chk("relock_ready_edge15", 32'(ready), 32'd3);

        // soft_rst[1] pulse in RUN affects channel 1 only.
        soft_rst = 2'b10;
        tick();
        soft_rst = 2'b00;
        chk("soft_phy_after", 32'(phy_reset_b), 32'd1);
        chk("soft_ready_after", 32'(ready), 32'd1);
        repeat (7) tick();
        chk("soft_phy_hold7", 32'(phy_reset_b), 32'd1);
        tick();
        chk("soft_phy_rel8", 32'(phy_reset_b), 32'd3);
        repeat (3) tick();
        chk("soft_ready_11", 32'(ready), 32'd1);
        tick();
        chk("soft_ready_12", 32'(ready), 32'd3);

        // Mid-sequence reset while both channels are settling.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (12) tick();
        chk("mid_settle_phy",   32'(phy_reset_b), 32'd3);
        chk("mid_settle_ready", 32'(ready),       32'd0);
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (10) tick();
        chk("mid_phy_edge10", 32'(phy_reset_b), 32'd0);
        tick();
        chk("mid_phy_edge11", 32'(phy_reset_b), 32'd3);

        // 300 lock losses saturate the restart counter.
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b1;
            repeat (4) tick();
            pll_locked = 1'b0;
            tick();
        end
        chk("sat_cnt",  32'(restart_cnt), 32'd255);
        chk("sat_lost", 32'(lock_lost),   32'd1);
        pll_locked = 1'b1;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_cnt",  32'(restart_cnt), 32'd0);
        chk("clr_lost", 32'(lock_lost),   32'd0);
        repeat (4) tick();
        pll_locked = 1'b0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        pll_locked = 1'b1;
        chk("clr_loss_cnt",  32'(restart_cnt), 32'd1);
        chk("clr_loss_lost", 32'(lock_lost),   32'd1);

        // Random phase: mostly locked, with rare drops, soft resets,
        // clears and resets; the per-cycle compare does the checking.
        for (int k = 0; k < 4000; k++) begin
            pll_locked = ($urandom_range(39) != 0);
            for (int c = 0; c < N_CH; c++) soft_rst[c] = ($urandom_range(79) == 0);
            clr_status = ($urandom_range(99) == 0);
            rst_n      = ($urandom_range(499) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
